// File: rtl/key_event_pkg.sv
// key_event_pkg
// Shared definitions for the front-panel key event generator:
//   - FSM state encoding for the press / auto-repeat controller
//   - key index constants into the {clr, dn, up} vectors
//   - default timing constants for a 48 kHz system clock
//   - helper that turns a key index into a one-hot pulse vector
package key_event_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2,
      LOCK   = 2'd3
   } key_state_t;

   localparam int KEY_UP   = 0;
   localparam int KEY_DN   = 1;
   localparam int KEY_CLR  = 2;
   localparam int NUM_KEYS = 3;

   // 20 ms debounce, 0.5 s first repeat, 0.25 s repeat interval at 48 kHz
   localparam int DEF_DEBOUNCE_CYCLES = 960;
   localparam int DEF_REPEAT_DELAY    = 24000;
   localparam int DEF_REPEAT_PERIOD   = 12000;

   function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [1:0] key);
      return 3'b001 << key;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce
// One raw active-low push switch: 2-flop synchroniser followed by a
// counter-based debouncer. The accepted level only flips after the
// synchronised level has differed from it for DEBOUNCE_CYCLES cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sw_n       : raw switch, asynchronous, 0 = pressed
//   held       : accepted level, 1 = pressed
//   held_d     : accepted level delayed by one cycle
//   press      : high for one cycle after the accepted level goes pressed
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 960
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_n,
   output logic held,
   output logic held_d,
   output logic press
);

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic        sync1_reg;
   logic        sync2_reg;
   logic        level_reg;
   logic        level_d_reg;
   logic [15:0] cnt_reg;
   logic        pressed_now;

   assign pressed_now = ~sync2_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
         level_reg   <= 1'b0;
         level_d_reg <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         sync1_reg   <= sw_n;
         sync2_reg   <= sync1_reg;
         level_d_reg <= level_reg;
         if (pressed_now == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            level_reg <= pressed_now;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 16'd1;
         end
      end
   end

   // The controller works on the delayed level so that its press and
   // release views are taken from the same pipeline stage.
   assign held   = level_reg;
   assign held_d = level_d_reg;
   assign press  = level_reg & ~level_d_reg;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen
// Front-panel key input stage: debounces the up / down / clear switches
// and produces single-cycle command pulses, with press-and-hold
// auto-repeat for up and down. Only one key is serviced at a time;
// priority is up > down > clear.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   sw_up_n, sw_dn_n, sw_clr_n  : raw switches, 0 = pressed
//   inc_pulse, dec_pulse,
//   clr_pulse                   : registered one-cycle commands
//   keys_held                   : debounced levels {clr, dn, up}, 1 = pressed
module key_event_gen
   import key_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sw_up_n,
   input  logic       sw_dn_n,
   input  logic       sw_clr_n,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       clr_pulse,
   output logic [2:0] keys_held
);

   localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
   localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

   logic [NUM_KEYS-1:0] sw_vec;
   logic [NUM_KEYS-1:0] held_vec;
   logic [NUM_KEYS-1:0] held_d_vec;
   logic [NUM_KEYS-1:0] press_vec;

   assign sw_vec = {sw_clr_n, sw_dn_n, sw_up_n};

   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_deb
         sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_n   (sw_vec[gi]),
            .held   (held_vec[gi]),
            .held_d (held_d_vec[gi]),
            .press  (press_vec[gi])
         );
      end
   endgenerate

   assign keys_held = held_vec;

   key_state_t          state_reg, state_next;
   logic [1:0]          key_reg, key_next;
   logic [15:0]         timer_reg, timer_next;
   logic [NUM_KEYS-1:0] pulse_reg, pulse_next;
   logic [1:0]          sel;
   logic                latched_held;

   // Highest-priority key with a press event this cycle
   always_comb begin
      sel = 2'(KEY_CLR);
      if (press_vec[KEY_UP])
         sel = 2'(KEY_UP);
      else if (press_vec[KEY_DN])
         sel = 2'(KEY_DN);
   end

   always_comb begin
      case (key_reg)
         2'(KEY_UP): latched_held = held_d_vec[KEY_UP];
         2'(KEY_DN): latched_held = held_d_vec[KEY_DN];
         default:    latched_held = held_d_vec[KEY_CLR];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         key_reg   <= '0;
         timer_reg <= '0;
         pulse_reg <= '0;
      end else begin
         state_reg <= state_next;
         key_reg   <= key_next;
         timer_reg <= timer_next;
         pulse_reg <= pulse_next;
      end
   end

   // Release is tested before the repeat compare so a key let go on the
   // cycle a repeat falls due produces no pulse.
   always_comb begin
      state_next = state_reg;
      key_next   = key_reg;
      timer_next = timer_reg;
      pulse_next = '0;
      case (state_reg)
         IDLE: begin
            if (|press_vec) begin
               key_next   = sel;
               pulse_next = key_onehot(sel);
               timer_next = '0;
               state_next = (sel == 2'(KEY_CLR)) ? LOCK : HOLD;
            end
         end
         HOLD: begin
            if (!latched_held) begin
               state_next = IDLE;
            end else if (timer_reg == DELAY_LAST) begin
               pulse_next = key_onehot(key_reg);
               timer_next = '0;
               state_next = REPEAT;
            end else begin
               timer_next = timer_reg + 16'd1;
            end
         end
         REPEAT: begin
            if (!latched_held) begin
               state_next = IDLE;
            end else if (timer_reg == PERIOD_LAST) begin
               pulse_next = key_onehot(key_reg);
               timer_next = '0;
            end else begin
               timer_next = timer_reg + 16'd1;
            end
         end
         LOCK: begin
            if (!latched_held)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign inc_pulse = pulse_reg[KEY_UP];
   assign dec_pulse = pulse_reg[KEY_DN];
   assign clr_pulse = pulse_reg[KEY_CLR];

endmodule

// File: tb/tb_key_event_gen.sv
module tb_key_event_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sw_up_n, sw_dn_n, sw_clr_n;
   logic       inc_pulse, dec_pulse, clr_pulse;
   logic [2:0] keys_held;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int base  = 0;
   int inc_q[$];
   int dec_q[$];
   int clr_q[$];
   int held0_first;
   int held0_count;
   int exp_q[$];
   int none_q[$];

   always #5 clk = ~clk;

   key_event_gen #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (10)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_up_n   (sw_up_n),
      .sw_dn_n   (sw_dn_n),
      .sw_clr_n  (sw_clr_n),
      .inc_pulse (inc_pulse),
      .dec_pulse (dec_pulse),
      .clr_pulse (clr_pulse),
      .keys_held (keys_held)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: sample 1 time unit after the rising edge and log pulses
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (inc_pulse) inc_q.push_back(cyc);
      if (dec_pulse) dec_q.push_back(cyc);
      if (clr_pulse) clr_q.push_back(cyc);
      if (keys_held[0]) begin
         if (held0_first < 0) held0_first = cyc;
         held0_count++;
      end
      check($sformatf("onehot_c%0d", cyc),
            ($countones({inc_pulse, dec_pulse, clr_pulse}) <= 1) ? 1 : 0, 1);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic start();
      inc_q.delete();
      dec_q.delete();
      clr_q.delete();
      held0_first = -1;
      held0_count = 0;
      base = cyc;
   endtask

   task automatic check_q(input string tag, input int got[$], input int exp[$]);
      check({tag, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s_%0d", tag, i), got[i] - base, exp[i]);
   endtask

   initial begin
      none_q = {};
      rst_n = 1'b0;
      sw_up_n = 1'b1; sw_dn_n = 1'b1; sw_clr_n = 1'b1;
      start();
      run(3);
      check("rst_pulses", {29'd0, inc_pulse, dec_pulse, clr_pulse}, 0);
      check("rst_held", {29'd0, keys_held}, 0);
      rst_n = 1'b1;
      run(5);
      check("idle_pulses", {29'd0, inc_pulse, dec_pulse, clr_pulse}, 0);
      check("idle_held", {29'd0, keys_held}, 0);

      // Clean press of 15 cycles
      start();
      sw_up_n = 1'b0; run(15);
      sw_up_n = 1'b1; run(25);
      exp_q = '{7};
      check_q("clean_inc", inc_q, exp_q);
      check_q("clean_dec", dec_q, none_q);
      check_q("clean_clr", clr_q, none_q);
      check("clean_held_rise", held0_first - base, 6);
      check("clean_held_len", held0_count, 15);

      // Bouncing down switch, final fall at +12
      start();
      sw_dn_n = 1'b0; run(2);
      sw_dn_n = 1'b1; run(2);
      sw_dn_n = 1'b0; run(2);
      sw_dn_n = 1'b1; run(2);
      sw_dn_n = 1'b0; run(2);
      sw_dn_n = 1'b1; run(2);
      sw_dn_n = 1'b0; run(10);
      sw_dn_n = 1'b1; run(25);
      exp_q = '{19};
      check_q("bounce_dec", dec_q, exp_q);
      check_q("bounce_inc", inc_q, none_q);

      // Auto-repeat, up held 60 cycles
      start();
      sw_up_n = 1'b0; run(60);
      sw_up_n = 1'b1; run(25);
      exp_q = '{7, 27, 37, 47, 57, 67};
      check_q("repeat_inc", inc_q, exp_q);
      check("repeat_held_end", {29'd0, keys_held}, 0);

      // Simultaneous up+down, down held longer than up
      start();
      sw_up_n = 1'b0; sw_dn_n = 1'b0; run(25);
      sw_up_n = 1'b1; run(20);
      sw_dn_n = 1'b1; run(25);
      exp_q = '{7, 27};
      check_q("simul_inc", inc_q, exp_q);
      check_q("simul_dec", dec_q, none_q);

      // Clear held 100 cycles: no repeat
      start();
      sw_clr_n = 1'b0; run(100);
      sw_clr_n = 1'b1; run(20);
      exp_q = '{7};
      check_q("clear_clr", clr_q, exp_q);
      check_q("clear_inc", inc_q, none_q);

      // Reset asserted while a repeat pulse is high
      start();
      sw_up_n = 1'b0; run(37);
      check("pre_rst_inc", {31'd0, inc_pulse}, 1);
      exp_q = '{7, 27, 37};
      check_q("pre_rst_q", inc_q, exp_q);
      rst_n = 1'b0;
      #1;
      check("async_rst_inc", {31'd0, inc_pulse}, 0);
      check("async_rst_held", {29'd0, keys_held}, 0);
      run(3);
      rst_n = 1'b1;
      start();
      run(40);
      check_q("post_rst_inc", inc_q, exp_q);
      sw_up_n = 1'b1; run(20);
      check("post_rst_held", {29'd0, keys_held}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
